// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter: FSM state encoding,
// header tag and the watchdog counter sizing function.
package uart_arb_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      GRANT     = 3'd1,
      START     = 3'd2,
      WAIT_DONE = 3'd3,
      HDR_START = 3'd4,
      HDR_WAIT  = 3'd5
   } arb_state_t;

   localparam logic [3:0] HDR_TAG = 4'hA;

   // Bits needed to count 0 .. cyc-1; never narrower than one bit.
   function automatic int wdog_width(input int cyc);
      return (cyc < 2) ? 1 : $clog2(cyc);
   endfunction

   function automatic logic [7:0] hdr_byte(input logic [2:0] id);
      return {HDR_TAG, 1'b0, id};
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector, first set bit at or above ptr
// with wrap-around. Shared with other arbiters in the codebase.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [IDW-1:0]  idx,
   output logic            found
);

   localparam int PW = IDW + 1;

   logic [2*NREQ-1:0] dbl;
   logic [NREQ-1:0]   rot;
   logic [PW-1:0]     sum;

   always_comb begin
      dbl   = {req, req};
      rot   = NREQ'(dbl >> ptr);
      found = 1'b0;
      sum   = '0;
      // Scan downward so the lowest offset from ptr is the one that sticks.
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (rot[k]) begin
            sum   = PW'(ptr) + PW'(k);
            found = 1'b1;
         end
      end
      if (sum >= PW'(NREQ))
         sum = sum - PW'(NREQ);
      idx = sum[IDW-1:0];
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among NREQ byte
// sources, with a done watchdog. Define UART_ARB_ID_HDR_EN to prefix each byte
// with a requester-ID header byte.
//
//  state     | meaning
//  ----------+--------------------------------------------------------------
//  IDLE      | waiting for any req_valid; picks next requester from rr_ptr
//  GRANT     | accept strobe to grant_id, capture its byte (or abandon)
//  START     | one-cycle tx_start for the payload byte, watchdog cleared
//  WAIT_DONE | waiting for tx_done, watchdog counting
//  HDR_START | one-cycle tx_start for the header byte (option only)
//  HDR_WAIT  | waiting for tx_done of the header, watchdog counting (option)
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NREQ        = 4,
   parameter int IDW         = 2,
   parameter int TIMEOUT_CYC = 200000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [8*NREQ-1:0] req_data,
   output logic [NREQ-1:0]   req_ready,
   output logic              tx_start,
   output logic [7:0]        tx_data,
   input  logic              tx_done,
   output logic              busy,
   output logic [IDW-1:0]    grant_id,
   output logic              err_timeout
);

   localparam int WDW = wdog_width(TIMEOUT_CYC);

   arb_state_t      state;
   logic [IDW-1:0]  rr_ptr;
   logic [IDW-1:0]  pick_idx;
   logic            pick_found;
   logic [IDW-1:0]  ptr_next;
   logic [WDW-1:0]  wdog;
   logic            wdog_expired;
   logic [7:0]      sel_byte;
`ifdef UART_ARB_ID_HDR_EN
   logic [7:0]      hold;
`endif

   rr_pick #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_rr_pick (
      .req   (req_valid),
      .ptr   (rr_ptr),
      .idx   (pick_idx),
      .found (pick_found)
   );

   assign sel_byte     = req_data[{grant_id, 3'b000} +: 8];
   assign ptr_next     = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
   assign wdog_expired = (wdog == WDW'(TIMEOUT_CYC - 1));
   assign busy         = (state != IDLE);

`ifdef UART_ARB_ID_HDR_EN
   assign tx_start    = (state == START) || (state == HDR_START);
   assign err_timeout = ((state == WAIT_DONE) || (state == HDR_WAIT))
                        && wdog_expired && !tx_done;
`else
   assign tx_start    = (state == START);
   assign err_timeout = (state == WAIT_DONE) && wdog_expired && !tx_done;
`endif

   // Accept strobe is withheld if the requester withdrew before GRANT.
   always_comb begin
      req_ready = '0;
      if (state == GRANT && req_valid[grant_id])
         req_ready[grant_id] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         grant_id <= '0;
         rr_ptr   <= '0;
         wdog     <= '0;
         tx_data  <= '0;
`ifdef UART_ARB_ID_HDR_EN
         hold     <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (pick_found) begin
                  grant_id <= pick_idx;
                  state    <= GRANT;
               end
            end

            GRANT: begin
               if (req_valid[grant_id]) begin
`ifdef UART_ARB_ID_HDR_EN
                  hold    <= sel_byte;
                  tx_data <= hdr_byte(3'(grant_id));
                  state   <= HDR_START;
`else
                  tx_data <= sel_byte;
                  state   <= START;
`endif
               end else begin
                  state <= IDLE;
               end
            end

            START: begin
               wdog  <= '0;
               state <= WAIT_DONE;
            end

            WAIT_DONE: begin
               // tx_done takes priority over a watchdog expiry in the same cycle.
               if (tx_done || wdog_expired) begin
                  rr_ptr <= ptr_next;
                  state  <= IDLE;
               end else begin
                  wdog <= wdog + 1'b1;
               end
            end

`ifdef UART_ARB_ID_HDR_EN
            HDR_START: begin
               wdog  <= '0;
               state <= HDR_WAIT;
            end

            HDR_WAIT: begin
               if (tx_done) begin
                  tx_data <= hold;
                  state   <= START;
               end else if (wdog_expired) begin
                  rr_ptr <= ptr_next;
                  state  <= IDLE;
               end else begin
                  wdog <= wdog + 1'b1;
               end
            end
`endif

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares one UART transmitter among NREQ byte requesters. Each requester presents a byte with valid/ready. The arbiter grants one requester, launches the transmitter with a one-cycle start pulse, and waits for the transmitter's done pulse before it grants again. A watchdog recovers the block if done never arrives. It sits between on-chip byte sources and the UART top's start/txin/txdone interface.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, width of grant_id; must be at least clog2(NREQ)
TIMEOUT_CYC, 200000, clk cycles allowed in WAIT_DONE before abort (covers 10 bits at the slowest baud with margin)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
req_valid  input  NREQ  requester i has a byte pending
req_data  input  8*NREQ  byte of requester i at bits [8i+7:8i]
req_ready  output  NREQ  one-hot; accept strobe for the granted requester
tx_start  output  1  one-cycle launch pulse to the UART transmitter
tx_data  output  8  byte to transmit; held stable from tx_start until done
tx_done  input  1  one-cycle pulse from the transmitter at end of the stop bit
busy  output  1  high in any state other than IDLE
grant_id  output  IDW  index of the current or last granted requester
err_timeout  output  1  one-cycle pulse when the watchdog fires

Behaviour:
- Decided interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: req_ready=0, tx_start=0, tx_data=0, busy=0, grant_id=0, err_timeout=0, state=IDLE, rr_ptr=0, wdog=0.
- States: IDLE -> GRANT -> START -> WAIT_DONE -> IDLE (with optional HDR states).
- IDLE: if any req_valid is set, select the first set bit scanning from rr_ptr upward with wrap. Register its index into grant_id. Go to GRANT.
- GRANT: req_ready[grant_id]=1 for exactly this cycle. Capture req_data[grant_id] into tx_data. Go to START.
  - If req_valid[grant_id] has dropped by this cycle, do not capture and return to IDLE. No byte is sent and rr_ptr is unchanged.
- START: tx_start=1 for this cycle only. Clear wdog. Go to WAIT_DONE.
- WAIT_DONE: wdog increments every cycle.
  - On tx_done=1: set rr_ptr=(grant_id+1) mod NREQ and go to IDLE.
  - If wdog reaches TIMEOUT_CYC-1 without tx_done: pulse err_timeout, advance rr_ptr the same way, go to IDLE.
  - If tx_done and the timeout occur in the same cycle, tx_done wins and there is no error pulse.
- tx_done is ignored outside WAIT_DONE.
- Minimum spacing between tx_start pulses is done latency + 3 cycles (IDLE, GRANT, START).
- Fairness: a continuously requesting requester is served at most once per NREQ grants while others are pending.
- Reset asserted mid-transfer returns to IDLE on the next edge. The UART may still finish its frame; the stray tx_done is ignored.
- tx_data changes only in GRANT (and in HDR when the option is enabled).

Optional Feature:
UART_ARB_ID_HDR_EN
- Defined: each grant sends two bytes.
  - First byte is the header {4'hA, 1'b0, grant_id zero-extended to 3 bits}.
  - Sequence: GRANT captures the payload into a hold register; HDR_START pulses tx_start with the header on tx_data; HDR_WAIT waits for tx_done (watchdog active); then START/WAIT_DONE send the payload.
  - A timeout in HDR_WAIT aborts both bytes.
- Undefined: single-byte flow as above; header logic is absent.

Decomposition:
- Package uart_arb_pkg:
  - state enum (IDLE, GRANT, START, WAIT_DONE, HDR_START, HDR_WAIT)
  - HDR_TAG=4'hA
  - the watchdog counter width function
- Sub-module rr_pick: combinational round-robin selector. Inputs are the req vector and rr_ptr; outputs are the index and a found flag. It is reused by other arbiters in the codebase.

Test Plan:
- Single request: req_valid=4'b0100, data 8'h5A -> req_ready=4'b0100 for one cycle; tx_start one cycle later with tx_data=8'h5A; busy drops the cycle after tx_done.
- All four valid, constant, with data 8'h10/11/12/13 -> grant order 0,1,2,3,0 and tx_data sequence 10,11,12,13,10.
- rr_ptr=2 with only requesters 0 and 3 valid -> grant 3 first, then 0.
- tx_done held low -> err_timeout pulses exactly TIMEOUT_CYC cycles after tx_start; next grant goes to the next index.
- Requester 1 drops valid in the same cycle as GRANT -> no tx_start and a return to IDLE; with UART_ARB_ID_HDR_EN, a grant to id 2 with data 8'h33 -> bytes 8'hA2 then 8'h33.
- rst pulsed during WAIT_DONE, followed by a stray tx_done -> all outputs are at reset values and no grant occurs until req_valid is seen in IDLE.
